// File: rtl/relogio_display.sv
// rtl/relogio_display.sv - four-digit multiplexed HH:MM clock display with snapshot capture
module relogio_display #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dhourq,
  input  logic [3:0] uhourq,
  input  logic [3:0] dminq,
  input  logic [3:0] uminq,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       colon,
  output logic       err
);

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

  localparam logic [15:0] SLOT_LAST  = 16'(SCAN_DIV - 2);
  localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] slot_q, slot_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] snap_q, snap_d;
  logic [23:0] blink_q, blink_d;
  logic        colon_q, colon_d;
  logic        err_q, err_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        ready_q, ready_d;
  logic        handshake;
  logic        digits_ok;
  logic [3:0]  cur_val;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b0111111;
      4'd1:    enc = 7'b0000110;
      4'd2:    enc = 7'b1011011;
      4'd3:    enc = 7'b1001111;
      4'd4:    enc = 7'b1100110;
      4'd5:    enc = 7'b1101101;
      4'd6:    enc = 7'b1111101;
      4'd7:    enc = 7'b0000111;
      4'd8:    enc = 7'b1111111;
      4'd9:    enc = 7'b1101111;
      default: enc = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    digit_d = digit_q;
    snap_d  = snap_q;
    blink_d = blink_q;
    colon_d = colon_q;
    err_d   = err_q;

    handshake = load_valid && ready_q;
    digits_ok = (dhourq <= 4'd2) && (uhourq <= 4'd9) && (dminq <= 4'd5) &&
                (uminq <= 4'd9) && !((dhourq == 4'd2) && (uhourq > 4'd3));

    // A rejected capture still completes the handshake; only err records it.
    if (handshake) begin
      if (digits_ok) snap_d = {dhourq, uhourq, dminq, uminq};
      else           err_d  = 1'b1;
    end

    case (state_q)
      SHOW: begin
        if (slot_q == SLOT_LAST) begin
          state_d = GAP;
          slot_d  = 16'd0;
        end else begin
          slot_d = slot_q + 16'd1;
        end
      end
      default: begin
        state_d = SHOW;
        digit_d = digit_q - 2'd1;
      end
    endcase

    if (blink_q == BLINK_LAST) begin
      blink_d = 24'd0;
      colon_d = ~colon_q;
    end else begin
      blink_d = blink_q + 24'd1;
    end

    // Outputs are registered, so they are derived from the next state.
    cur_val = snap_d[{digit_d, 2'b00} +: 4];
    if ((state_d == SHOW) && !((digit_d == 2'd3) && (cur_val == 4'd0))) begin
      an_d  = 4'b0001 << digit_d;
      seg_d = enc(cur_val);
    end else begin
      an_d  = 4'b0000;
      seg_d = 7'b0000000;
    end
    ready_d = (state_d == GAP) && (digit_d == 2'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SHOW;
      slot_q  <= 16'd0;
      digit_q <= 2'd3;
      snap_q  <= 16'd0;
      blink_q <= 24'd0;
      colon_q <= 1'b1;
      err_q   <= 1'b0;
      seg_q   <= 7'b0000000;
      an_q    <= 4'b0000;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
      blink_q <= blink_d;
      colon_q <= colon_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ready_q <= ready_d;
    end
  end

  assign load_ready = ready_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign colon      = colon_q;
  assign err        = err_q;

endmodule
